// File: rtl/fetch_stage_if.sv
// Shared address/word types and the bus bundle between the fetch stage, the
// instruction ROM, execute (redirects) and decode (IF/ID handshake).
package fetch_pkg;
  typedef logic [9:0]  RomAddress;
  typedef logic [31:0] UWord;
endpackage

interface fetch_stage_if;
  import fetch_pkg::*;

  RomAddress   rom_address;
  UWord        rom_data;
  logic        redirect_valid;
  RomAddress   redirect_pc;
  logic        out_valid;
  logic        out_ready;
  RomAddress   out_pc;
  UWord        out_instr;
  logic        out_fault;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output rom_address,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_fault,
    output halted,
    output fetch_count
  );

  modport slave (
    input  rom_address,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_fault,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers the returned word into the IF/ID slot drained by decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter RomAddress RESET_PC  = '0,
  parameter UWord      NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          reset_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e      state_q, state_d;
  RomAddress   pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  RomAddress   out_pc_q, out_pc_d;
  UWord        out_instr_q, out_instr_d;
  logic        out_fault_q, out_fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic advance;
  logic accept;

  assign advance = !out_valid_q || bus.out_ready;
  assign accept  = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Handing a fault marker to decode is the only way out of RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (accept && out_fault_q) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    out_fault_d   = out_fault_q;
    fetch_count_d = fetch_count_q;
    if (state_q == RUN) begin
      if (accept) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
      if (accept && out_fault_q) begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
      end else if (bus.redirect_valid) begin
        // Wrong-path flush: the slot empties, one bubble before the target.
        pc_d        = bus.redirect_pc;
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
      end else if (advance) begin
        out_valid_d = 1'b1;
        out_pc_d    = pc_q;
        if (pc_q[1:0] == 2'b00) begin
          out_instr_d = bus.rom_data;
          out_fault_d = 1'b0;
          pc_d        = pc_q + RomAddress'(4);
        end else begin
          out_instr_d = NOP_INSTR;
          out_fault_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= NOP_INSTR;
      out_fault_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      out_fault_q   <= out_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.rom_address = pc_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_fault   = out_fault_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized episodes checked every cycle against a behavioural model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int ADDR_SPAN = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] rom [256];
  fetch_stage_if bus();

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: byte-address arithmetic over a 1 KiB space.
  int          m_pc;
  int          m_opc;
  bit          m_valid;
  bit          m_fault;
  bit          m_halted;
  bit          m_boot;
  logic [31:0] m_instr;
  int unsigned m_count;

  fetch_stage #(.RESET_PC('0), .NOP_INSTR(NOP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_address[9:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 0; m_opc = 0; m_valid = 0; m_fault = 0;
      m_halted = 0; m_boot = 1; m_instr = NOP; m_count = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halted) begin
      bit accepted;
      accepted = m_valid && bus.out_ready;
      if (accepted) m_count++;
      if (accepted && m_fault) begin
        m_halted = 1; m_valid = 0; m_instr = NOP;
      end else if (bus.redirect_valid) begin
        m_pc = int'(bus.redirect_pc); m_valid = 0; m_instr = NOP;
      end else if (!m_valid || bus.out_ready) begin
        m_valid = 1;
        m_opc = m_pc;
        if (m_pc % 4 == 0) begin
          m_instr = rom[m_pc / 4];
          m_fault = 0;
          m_pc = (m_pc + 4) % ADDR_SPAN;
        end else begin
          m_instr = NOP;
          m_fault = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid",   {31'b0, bus.out_valid}, {31'b0, m_valid});
      check("out_instr",   bus.out_instr, m_instr);
      check("halted",      {31'b0, bus.halted}, {31'b0, m_halted});
      check("fetch_count", bus.fetch_count, m_count);
      check("rom_address", {22'b0, bus.rom_address}, m_pc);
      if (m_valid) begin
        check("out_pc",    {22'b0, bus.out_pc}, m_opc);
        check("out_fault", {31'b0, bus.out_fault}, {31'b0, m_fault});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit rdy, input bit rv, input logic [9:0] rpc);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    applyStimulus(1'b1, 1'b0, '0);
    tick(); tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Boot bubble, then sequential fetch
    tick();
    checkOutput("boot_valid", {31'b0, bus.out_valid}, 32'd0);
    tick();
    checkOutput("f0_pc", {22'b0, bus.out_pc}, 32'h0);
    checkOutput("f0_instr", bus.out_instr, rom[0]);
    tick();
    checkOutput("f1_pc", {22'b0, bus.out_pc}, 32'h4);
    tick();
    checkOutput("f2_pc", {22'b0, bus.out_pc}, 32'h8);
    checkOutput("f2_instr", bus.out_instr, rom[2]);
    checkOutput("f2_count", bus.fetch_count, 32'd2);

    // Stall holds the slot and pc
    applyStimulus(1'b0, 1'b0, '0);
    tick(); tick(); tick();
    checkOutput("stall_pc", {22'b0, bus.out_pc}, 32'h8);
    checkOutput("stall_instr", bus.out_instr, rom[2]);
    checkOutput("stall_rom_addr", {22'b0, bus.rom_address}, 32'hC);
    checkOutput("stall_count", bus.fetch_count, 32'd2);
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkOutput("release_pc", {22'b0, bus.out_pc}, 32'hC);
    checkOutput("release_count", bus.fetch_count, 32'd3);

    // Redirect while stalled
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b1, 10'h040);
    tick();
    checkOutput("redir_bubble", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("redir_nop", bus.out_instr, NOP);
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkOutput("redir_pc", {22'b0, bus.out_pc}, 32'h40);
    checkOutput("redir_instr", bus.out_instr, rom[16]);
    checkOutput("redir_count", bus.fetch_count, 32'd3);

    // Top-of-space wrap
    applyStimulus(1'b1, 1'b1, 10'h3FC);
    tick();
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkOutput("top_pc", {22'b0, bus.out_pc}, 32'h3FC);
    tick();
    checkOutput("wrap_pc", {22'b0, bus.out_pc}, 32'h0);

    // Async reset mid-stall
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_instr", bus.out_instr, NOP);
    checkOutput("rst_pc", {22'b0, bus.out_pc}, 32'h0);
    checkOutput("rst_count", bus.fetch_count, 32'd0);
    checkOutput("rst_fault", {31'b0, bus.out_fault}, 32'd0);
    checkOutput("rst_rom_addr", {22'b0, bus.rom_address}, 32'h0);
    tick();
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkOutput("reboot_valid", {31'b0, bus.out_valid}, 32'd0);
    tick();
    checkOutput("reboot_pc", {22'b0, bus.out_pc}, 32'h0);

    // Misaligned redirect faults, then halts
    applyStimulus(1'b1, 1'b1, 10'h042);
    tick();
    checkOutput("mis_bubble", {31'b0, bus.out_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkOutput("mis_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("mis_fault", {31'b0, bus.out_fault}, 32'd1);
    checkOutput("mis_instr", bus.out_instr, NOP);
    tick();
    checkOutput("halt_flag", {31'b0, bus.halted}, 32'd1);
    checkOutput("halt_valid", {31'b0, bus.out_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 10'h010);
    tick(); tick(); tick();
    checkOutput("halt_hold", {31'b0, bus.halted}, 32'd1);
    checkOutput("halt_pc", {22'b0, bus.rom_address}, 32'h42);

    // Randomized episodes against the model
    for (int ep = 0; ep < 25; ep++) begin
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 150; c++) begin
        logic [9:0] target;
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0)      target = 10'($urandom);
        else if (sel == 1) target = 10'h3F8;
        else               target = {8'($urandom_range(0, 255)), 2'b00};
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, target);
        tick();
      end
    end

    applyStimulus(1'b0, 1'b0, '0);
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
